// File: rtl/pll_seq_pkg.sv
// Purpose : shared types and constants for the PLL lock/reset sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

    localparam int STATE_W     = 3;
    localparam int MAX_DOMAINS = 8;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAILED    = 3'd5
    } seq_state_t;

    // Largest of four values; used to size the shared cycle counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose : two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency : 2 clk cycles from d to q.
// Backpressure: none; level signal, sampled every cycle.
// Ports   : clk, rst (sync active-high, clears both stages), d (async in), q (synchronized out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Purpose : drives PLL RST, qualifies LOCK, then releases domain resets in order (bit 0 first).
// Latency : lock decisions lag the raw locked pin by 2 cycles; outputs are registered (+1).
// Backpressure: none; loss of lock or relock_req forces a full restart on the next cycle.
// Ports   : clk, rst (sync active-high), locked (async PLL LOCK), relock_req (1-cycle pulse),
//           pll_rst, rst_out[NUM_DOMAINS], ready, fail (sticky), state (debug encoding).
// Build   : define LOCK_LOSS_CNT_EN to add the 8-bit saturating lock_loss_cnt output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 8,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   fail,
    output logic [STATE_W-1:0]     state
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]             lock_loss_cnt
`endif
);

    localparam int CNT_MAX = max4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTRY_W  = $clog2(MAX_RETRIES + 1);
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    // Terminal values: a phase of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0]  RST_TERM  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_TERM   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STB_TERM  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_TERM  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [RTRY_W-1:0] RTRY_LAST = RTRY_W'(MAX_RETRIES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic              lock_s;
    seq_state_t        st;
    logic [CNT_W-1:0]  cnt;
    logic [RTRY_W-1:0] retry;
    logic [IDX_W-1:0]  rel_idx;     // index of the most recently released rst_out bit
    logic              lock_lost;
    logic              restart;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    assign lock_lost = ((st == RELEASE) || (st == RUN)) && !lock_s;
    // Loss of lock and relock_req together collapse into a single restart.
    assign restart   = (st != FAILED) && (relock_req || lock_lost);
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= PLL_RST;
            cnt     <= '0;
            retry   <= '0;
            rel_idx <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            fail    <= 1'b0;
        end else if (restart) begin
            st      <= PLL_RST;
            cnt     <= '0;
            rel_idx <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            case (st)
                PLL_RST: begin
                    if (cnt >= RST_TERM) begin
                        st      <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= STABLE;
                        cnt <= '0;
                    end else if (cnt >= TO_TERM) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        retry   <= retry + 1'b1;
                        if (retry >= RTRY_LAST) begin
                            st   <= FAILED;
                            fail <= 1'b1;
                        end else begin
                            st <= PLL_RST;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        st  <= WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt >= STB_TERM) begin
                        // First domain is released on entry to RELEASE.
                        cnt     <= '0;
                        retry   <= '0;
                        rel_idx <= '0;
                        rst_out <= rst_out << 1;
                        if (NUM_DOMAINS == 1) begin
                            st    <= RUN;
                            ready <= 1'b1;
                        end else begin
                            st <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt >= GAP_TERM) begin
                        cnt     <= '0;
                        rst_out <= rst_out << 1;
                        rel_idx <= rel_idx + 1'b1;
                        // ready rises together with the last rst_out bit falling.
                        if ((rel_idx + 1'b1) >= IDX_LAST) begin
                            st    <= RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    st <= RUN;
                end
                FAILED: begin
                    if (relock_req) begin
                        st    <= PLL_RST;
                        cnt   <= '0;
                        retry <= '0;
                        fail  <= 1'b0;
                    end
                end
                default: begin
                    st      <= PLL_RST;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    // Counts only restarts caused by lock loss; relock_req alone is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    localparam int ND = 2;
    localparam int RC = 4;
    localparam int LT = 64;
    localparam int SC = 16;
    localparam int RG = 3;
    localparam int MR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;
    localparam int P_FAIL = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          locked;
    logic          relock_req;
    logic          pll_rst;
    logic [ND-1:0] rst_out;
    logic          ready;
    logic          fail;
    logic [2:0]    state;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]    lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .NUM_DOMAINS  (ND),
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .RELEASE_GAP  (RG),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .fail         (fail),
        .state        (state)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    // Reference model: phase + time-in-phase; outputs derived from those.
    int m_phase = P_RST;
    int m_t     = 0;
    int m_retry = 0;
    bit m_fail  = 1'b0;
    int m_llc   = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    function automatic logic [ND-1:0] m_rst_out();
        logic [ND-1:0] v;
        v = '1;
        if (m_phase == P_RUN) v = '0;
        else if (m_phase == P_REL)
            for (int i = 0; i < ND; i++) v[i] = (m_t >= i * RG) ? 1'b0 : 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] model_vec();
        logic pr;
        pr = (m_phase == P_RST) || (m_phase == P_FAIL);
`ifdef LOCK_LOSS_CNT_EN
        return {3'(m_phase), pr, m_rst_out(), (m_phase == P_RUN), m_fail, 8'(m_llc)};
`else
        return {3'(m_phase), pr, m_rst_out(), (m_phase == P_RUN), m_fail, 8'h00};
`endif
    endfunction

    function automatic logic [15:0] dut_vec();
`ifdef LOCK_LOSS_CNT_EN
        return {state, pll_rst, rst_out, ready, fail, lock_loss_cnt};
`else
        return {state, pll_rst, rst_out, ready, fail, 8'h00};
`endif
    endfunction

    task automatic model_step();
        bit ls;
        bit in_rr;
        ls    = m_s2;
        in_rr = (m_phase == P_REL) || (m_phase == P_RUN);
        if (rst) begin
            m_phase = P_RST; m_t = 0; m_retry = 0; m_fail = 1'b0; m_llc = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        if (m_phase != P_FAIL && (relock_req || (in_rr && !ls))) begin
            if (in_rr && !ls && m_llc < 255) m_llc++;
            m_phase = P_RST; m_t = 0;
        end else if (m_phase == P_FAIL) begin
            if (relock_req) begin
                m_phase = P_RST; m_t = 0; m_retry = 0; m_fail = 1'b0;
            end
        end else begin
            case (m_phase)
                P_RST: begin
                    m_t++;
                    if (m_t == RC) begin m_phase = P_WAIT; m_t = 0; end
                end
                P_WAIT: begin
                    if (ls) begin
                        m_phase = P_STAB; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == LT) begin
                            m_t = 0;
                            m_retry++;
                            if (m_retry == MR) begin m_phase = P_FAIL; m_fail = 1'b1; end
                            else m_phase = P_RST;
                        end
                    end
                end
                P_STAB: begin
                    if (!ls) begin
                        m_phase = P_WAIT; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == SC) begin
                            m_t = 0; m_retry = 0;
                            m_phase = (ND == 1) ? P_RUN : P_REL;
                        end
                    end
                end
                P_REL: begin
                    m_t++;
                    if (m_t == (ND - 1) * RG) m_phase = P_RUN;
                end
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = locked;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic chk_out(input string name, input logic [2:0] st, input logic pr,
                           input logic [1:0] ro, input logic rdy, input logic fl);
        check(name, {8'h00, state, pll_rst, rst_out, ready, fail},
                    {8'h00, st, pr, ro, rdy, fl});
    endtask

    task automatic chk_llc(input string name, input int e);
`ifdef LOCK_LOSS_CNT_EN
        check(name, {8'h00, lock_loss_cnt}, 16'(e));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        int         ncyc;
        logic       lk;
        logic       rr;
        logic [2:0] st;
        logic       pr;
        logic [1:0] ro;
        logic       rdy;
        logic       fl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int hold;
        int waited;

        tbl[0]  = '{3,  1'b0, 1'b0, 3'd0, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b0, 1'b0, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[2]  = '{5,  1'b0, 1'b0, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[3]  = '{2,  1'b1, 1'b0, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[4]  = '{1,  1'b1, 1'b0, 3'd2, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[5]  = '{15, 1'b1, 1'b0, 3'd2, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[6]  = '{1,  1'b1, 1'b0, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[7]  = '{2,  1'b1, 1'b0, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[8]  = '{1,  1'b1, 1'b0, 3'd4, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[9]  = '{5,  1'b1, 1'b0, 3'd4, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[10] = '{1,  1'b1, 1'b1, 3'd0, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[11] = '{4,  1'b1, 1'b0, 3'd1, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[12] = '{1,  1'b1, 1'b0, 3'd2, 1'b0, 2'b11, 1'b0, 1'b0};

        rst = 1'b1; locked = 1'b0; relock_req = 1'b0;
        repeat (3) cycle();
        chk_out("reset_values", 3'd0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk_llc("reset_llc", 0);
        rst = 1'b0;

        // Test 1: bring-up with locked rising at cycle 10, then a relock pulse.
        for (int i = 0; i < 13; i++) begin
            locked = tbl[i].lk;
            relock_req = tbl[i].rr;
            repeat (tbl[i].ncyc) cycle();
            relock_req = 1'b0;
            chk_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].pr, tbl[i].ro, tbl[i].rdy, tbl[i].fl);
        end

        // Test 2: locked held low -> two timeouts -> FAILED.
        locked = 1'b0;
        do_reset();
        repeat (135) cycle();
        chk_out("timeout_last_wait", 3'd1, 1'b0, 2'b11, 1'b0, 1'b0);
        cycle();
        chk_out("timeout_failed", 3'd5, 1'b1, 2'b11, 1'b0, 1'b1);

        // Test 3: one-cycle glitch at stable count 10.
        locked = 1'b1;
        do_reset();
        repeat (15) cycle();
        locked = 1'b0;
        cycle();
        locked = 1'b1;
        repeat (2) cycle();
        chk_out("glitch_back_to_wait", 3'd1, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (16) cycle();
        chk_out("glitch_window_restart", 3'd2, 1'b0, 2'b11, 1'b0, 1'b0);
        cycle();
        chk_out("glitch_release", 3'd3, 1'b0, 2'b10, 1'b0, 1'b0);

        // Test 4: lock loss in RUN.
        repeat (3) cycle();
        chk_out("run_reached", 3'd4, 1'b0, 2'b00, 1'b1, 1'b0);
        locked = 1'b0;
        repeat (2) cycle();
        chk_out("loss_pending", 3'd4, 1'b0, 2'b00, 1'b1, 1'b0);
        cycle();
        chk_out("loss_restart", 3'd0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk_llc("loss_llc", 1);
        locked = 1'b1;
        repeat (40) cycle();
        chk_out("relocked_run", 3'd4, 1'b0, 2'b00, 1'b1, 1'b0);

        // Test 5: relock_req in RUN and in FAILED.
        relock_req = 1'b1;
        cycle();
        relock_req = 1'b0;
        chk_out("relock_run", 3'd0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk_llc("relock_llc", 1);
        repeat (40) cycle();
        chk_out("relock_run_again", 3'd4, 1'b0, 2'b00, 1'b1, 1'b0);
        locked = 1'b0;
        repeat (150) cycle();
        chk_out("fail_again", 3'd5, 1'b1, 2'b11, 1'b0, 1'b1);
        chk_llc("fail_llc", 2);
        relock_req = 1'b1;
        cycle();
        relock_req = 1'b0;
        chk_out("relock_failed", 3'd0, 1'b1, 2'b11, 1'b0, 1'b0);

        // Test 6: rst asserted mid-RELEASE.
        locked = 1'b1;
        waited = 0;
        while (rst_out !== 2'b10 && waited < 100) begin
            cycle();
            waited++;
        end
        check("wait_release", {15'h0, (rst_out === 2'b10)}, 16'h0001);
        rst = 1'b1;
        cycle();
        chk_out("rst_mid_release", 3'd0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk_llc("rst_mid_llc", 0);
        rst = 1'b0;
        repeat (40) cycle();
        chk_out("after_rst_run", 3'd4, 1'b0, 2'b00, 1'b1, 1'b0);

        // Randomized stretch against the model.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                locked = ($urandom_range(0, 3) != 0);
                hold   = int'($urandom_range(1, locked ? 60 : 140));
            end
            relock_req = ($urandom_range(0, 199) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            cycle();
            hold--;
        end
        relock_req = 1'b0;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
